// File: rtl/sync_updown_counter_if.sv
// Control, event and status signals of sync_updown_counter.
// The master drives the controls and the event line; the slave is the counter.
interface sync_updown_counter_if #(
  parameter int unsigned WIDTH = 3
);
  logic             en;
  logic             ld;
  logic             up;
  logic [WIDTH-1:0] Q_in;
  logic             ev;
  logic             clr_ovf;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             ovf;

  modport master (
    output en, ld, up, Q_in, ev, clr_ovf,
    input  Q, tc, ovf
  );

  modport slave (
    input  en, ld, up, Q_in, ev, clr_ovf,
    output Q, tc, ovf
  );
endinterface

// File: rtl/sync_updown_counter.sv
// Single-clock up/down event counter with parallel load, terminal-count pulse
// and sticky overflow flag; wraps or saturates at the boundaries.
module sync_updown_counter #(
  parameter int unsigned WIDTH    = 3,
  parameter bit          SYNC     = 1'b1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  sync_updown_counter_if.slave  bus
);

  logic             s;
  logic             h_q;
  logic             rise;
  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  // Flops reset high so a level already high at reset is not taken as an edge.
  if (SYNC) begin : g_sync
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= 2'b11;
      end else begin
        sync_q <= {sync_q[0], bus.ev};
      end
    end
    assign s = sync_q[1];
  end else begin : g_nosync
    assign s = bus.ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= 1'b1;
    end else begin
      h_q <= s;
    end
  end

  assign rise     = s & ~h_q;
  assign step     = bus.en & rise & ~bus.ld;
  assign boundary = step & (bus.up ? (count_q == {WIDTH{1'b1}}) : (count_q == '0));

  always_comb begin
    count_d = count_q;
    if (bus.ld) begin
      count_d = bus.Q_in;
    end else if (step) begin
      if (!(boundary && SATURATE)) begin
        count_d = bus.up ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
    // Load suppresses step, so a load always yields tc = 0.
    tc_d  = boundary;
    ovf_d = boundary | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.Q   = count_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule
